// File: rtl/hyp_err_monitor_if.sv
// Stream and result bundle between the evaluation harness and hyp_err_monitor.
// The harness is the master and drives the run control and the result pairs.
interface hyp_err_monitor_if #(
  parameter int WIDTH = 128,
  parameter int CNT_W = 32,
  parameter int ACC_W = WIDTH + CNT_W
);
  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] approx;
  logic [WIDTH-1:0] exact;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] err_count;
  logic [WIDTH-1:0] max_err;
  logic [ACC_W-1:0] sum_err;
  logic             sum_sat;

  modport master (
    output start, num_samples, in_valid, approx, exact,
    input  in_ready, busy, done, err_count, max_err, sum_err, sum_sat
  );

  modport slave (
    input  start, num_samples, in_valid, approx, exact,
    output in_ready, busy, done, err_count, max_err, sum_err, sum_sat
  );
endinterface

// File: rtl/hyp_err_monitor.sv
// Error-metric sink for the approximate hyp_128b datapath: counts mismatches,
// tracks the largest absolute error and a saturating sum over a programmed run.
module hyp_err_monitor #(
  parameter int WIDTH = 128,
  parameter int CNT_W = 32,
  parameter int ACC_W = WIDTH + CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  hyp_err_monitor_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] acc_cnt;
  logic             s1_valid;
  logic             s1_neq;
  logic [WIDTH-1:0] s1_diff;
  logic [CNT_W-1:0] err_count_q;
  logic [WIDTH-1:0] max_err_q;
  logic [ACC_W-1:0] sum_err_q;
  logic             sum_sat_q;

  logic             arm;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] diff;
  logic [ACC_W:0]   sum_ext;

  assign arm     = bus.start && (state == IDLE || state == DONE);
  assign accept  = bus.in_valid && (state == RUN);
  assign last    = (acc_cnt + CNT_W'(1)) == target;
  assign diff    = (bus.approx >= bus.exact) ? bus.approx - bus.exact
                                             : bus.exact - bus.approx;
  // One extra bit catches the carry-out that triggers saturation.
  assign sum_ext = {1'b0, sum_err_q} + {{(ACC_W + 1 - WIDTH){1'b0}}, s1_diff};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (bus.start) state_nxt = (bus.num_samples == '0) ? DONE : RUN;
      RUN:        if (accept && last) state_nxt = DRAIN;
      DRAIN:      state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      target   <= '0;
      acc_cnt  <= '0;
      s1_valid <= 1'b0;
      s1_neq   <= 1'b0;
      s1_diff  <= '0;
    end else begin
      state    <= state_nxt;
      s1_valid <= accept;
      if (accept) begin
        s1_diff <= diff;
        s1_neq  <= (bus.approx != bus.exact);
      end
      if (arm) begin
        target  <= bus.num_samples;
        acc_cnt <= '0;
      end else if (accept) begin
        acc_cnt <= acc_cnt + CNT_W'(1);
      end
    end
  end

  // Stage 2: fold the registered difference into the run metrics.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= '0;
      max_err_q   <= '0;
      sum_err_q   <= '0;
      sum_sat_q   <= 1'b0;
    end else if (arm) begin
      err_count_q <= '0;
      max_err_q   <= '0;
      sum_err_q   <= '0;
      sum_sat_q   <= 1'b0;
    end else if (s1_valid) begin
      err_count_q <= err_count_q + CNT_W'(s1_neq);
      if (s1_diff > max_err_q) max_err_q <= s1_diff;
      if (sum_ext[ACC_W]) begin
        sum_err_q <= '1;
        sum_sat_q <= 1'b1;
      end else begin
        sum_err_q <= sum_ext[ACC_W-1:0];
      end
    end
  end

  assign bus.in_ready  = (state == RUN);
  assign bus.busy      = (state == RUN) || (state == DRAIN);
  assign bus.done      = (state == DONE);
  assign bus.err_count = err_count_q;
  assign bus.max_err   = max_err_q;
  assign bus.sum_err   = sum_err_q;
  assign bus.sum_sat   = sum_sat_q;

endmodule

// File: tb/tb_hyp_err_monitor.sv
// Directed bench for hyp_err_monitor: a vector table for the main runs plus
// hand-written sequences for reset abort and sum saturation (ACC_W = WIDTH+1).
module tb_hyp_err_monitor;

  localparam int WIDTH = 128;
  localparam int CNT_W = 32;
  localparam int ACC_W = WIDTH + CNT_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hyp_err_monitor_if #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W))     bus();
  hyp_err_monitor_if #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(WIDTH + 1)) bus_s();

  hyp_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  hyp_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(WIDTH + 1)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s)
  );

  typedef struct {
    logic             start;
    logic [CNT_W-1:0] num;
    logic             valid;
    logic [WIDTH-1:0] approx;
    logic [WIDTH-1:0] exact;
    logic             exp_ready;
    logic             exp_busy;
    logic             exp_done;
    logic [CNT_W-1:0] exp_err;
    logic [WIDTH-1:0] exp_max;
    logic [ACC_W-1:0] exp_sum;
  } vec_t;

  localparam int NVEC = 20;
  vec_t tbl [NVEC];

  int tests_run = 0;
  int tests_failed = 0;

  function automatic vec_t mk(int s, int n, int v, int a, int e, int r,
                              int b, int d, int ec, int mx, int sm);
    vec_t x;
    x.start     = s[0];
    x.num       = CNT_W'(n);
    x.valid     = v[0];
    x.approx    = WIDTH'(a);
    x.exact     = WIDTH'(e);
    x.exp_ready = r[0];
    x.exp_busy  = b[0];
    x.exp_done  = d[0];
    x.exp_err   = CNT_W'(ec);
    x.exp_max   = WIDTH'(mx);
    x.exp_sum   = ACC_W'(sm);
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [191:0] act,
                             input logic [191:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.start       = v.start;
    bus.num_samples = v.num;
    bus.in_valid    = v.valid;
    bus.approx      = v.approx;
    bus.exact       = v.exact;
  endtask

  task automatic checkMain(input string tag, input logic busy_e, input logic done_e,
                           input int err_e, input int max_e, input int sum_e);
    checkOutput({tag, "_busy"}, 192'(bus.busy), 192'(busy_e));
    checkOutput({tag, "_done"}, 192'(bus.done), 192'(done_e));
    checkOutput({tag, "_err"},  192'(bus.err_count), 192'(err_e));
    checkOutput({tag, "_max"},  192'(bus.max_err), 192'(max_e));
    checkOutput({tag, "_sum"},  192'(bus.sum_err), 192'(sum_e));
    checkOutput({tag, "_sat"},  192'(bus.sum_sat), 192'(0));
  endtask

  logic [191:0] ones128;
  logic [191:0] ones129;
  logic [191:0] sum_two;

  initial begin
    ones128 = (192'(1) << 128) - 192'(1);
    ones129 = (192'(1) << 129) - 192'(1);
    sum_two = ones129 - 192'(1);

    //              s  n  v  a    e   rdy bsy dn err max sum
    tbl[0]  = mk(1, 0, 0, 0,   0,  0,  0,  1,  0,  0,  0);
    tbl[1]  = mk(1, 4, 0, 0,   0,  0,  1,  0,  0,  0,  0);
    tbl[2]  = mk(0, 0, 1, 10,  10, 1,  1,  0,  0,  0,  0);
    tbl[3]  = mk(0, 0, 1, 7,   12, 1,  1,  0,  0,  0,  0);
    tbl[4]  = mk(0, 0, 1, 100, 40, 1,  1,  0,  1,  5,  5);
    tbl[5]  = mk(0, 0, 1, 5,   5,  1,  1,  0,  2,  60, 65);
    tbl[6]  = mk(0, 0, 0, 0,   0,  0,  0,  1,  2,  60, 65);
    tbl[7]  = mk(0, 0, 1, 1,   2,  0,  0,  1,  2,  60, 65);
    tbl[8]  = mk(1, 3, 0, 0,   0,  0,  1,  0,  0,  0,  0);
    tbl[9]  = mk(0, 0, 1, 3,   1,  1,  1,  0,  0,  0,  0);
    tbl[10] = mk(0, 0, 0, 9,   9,  1,  1,  0,  1,  2,  2);
    tbl[11] = mk(0, 0, 0, 9,   9,  1,  1,  0,  1,  2,  2);
    tbl[12] = mk(0, 0, 1, 4,   8,  1,  1,  0,  1,  2,  2);
    tbl[13] = mk(0, 0, 1, 20,  20, 1,  1,  0,  2,  4,  6);
    tbl[14] = mk(0, 0, 1, 50,  0,  0,  0,  1,  2,  4,  6);
    tbl[15] = mk(0, 0, 1, 50,  0,  0,  0,  1,  2,  4,  6);
    tbl[16] = mk(1, 1, 0, 0,   0,  0,  1,  0,  0,  0,  0);
    tbl[17] = mk(0, 0, 1, 0,   9,  1,  1,  0,  0,  0,  0);
    tbl[18] = mk(0, 0, 0, 0,   0,  0,  0,  1,  1,  9,  9);
    tbl[19] = mk(1, 0, 0, 0,   0,  0,  0,  1,  0,  0,  0);

    rst = 1'b1;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    bus_s.start = 1'b0;
    bus_s.num_samples = '0;
    bus_s.in_valid = 1'b0;
    bus_s.approx = '0;
    bus_s.exact = '0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_ready", 192'(bus.in_ready), 192'(0));
    checkMain("reset", 1'b0, 1'b0, 0, 0, 0);
    tick();
    checkMain("idle", 1'b0, 1'b0, 0, 0, 0);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(tbl[i]);
      checkOutput($sformatf("vec%0d_ready", i), 192'(bus.in_ready), 192'(tbl[i].exp_ready));
      tick();
      checkMain($sformatf("vec%0d", i), tbl[i].exp_busy, tbl[i].exp_done,
                int'(tbl[i].exp_err), int'(tbl[i].exp_max), int'(tbl[i].exp_sum));
    end

    // Abort after two accepts; a start pulse mid-run must be ignored.
    applyStimulus(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    applyStimulus(mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tick();
    applyStimulus(mk(0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0));
    tick();
    checkMain("midrun", 1'b1, 1'b0, 1, 1, 1);
    checkOutput("midrun_ready", 192'(bus.in_ready), 192'(1));
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkMain("abort", 1'b0, 1'b0, 0, 0, 0);
    checkOutput("abort_ready", 192'(bus.in_ready), 192'(0));
    tick();
    checkMain("abort_discard", 1'b0, 1'b0, 0, 0, 0);
    applyStimulus(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    applyStimulus(mk(0, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0));
    tick();
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    checkMain("after_abort", 1'b0, 1'b1, 1, 2, 2);

    // Saturating sum on the narrow-accumulator instance.
    bus_s.start = 1'b1;
    bus_s.num_samples = CNT_W'(3);
    tick();
    bus_s.start = 1'b0;
    bus_s.in_valid = 1'b1;
    bus_s.approx = '1;
    bus_s.exact = '0;
    tick();
    tick();
    tick();
    bus_s.in_valid = 1'b0;
    checkOutput("sat_pre_sum", 192'(bus_s.sum_err), sum_two);
    checkOutput("sat_pre_flag", 192'(bus_s.sum_sat), 192'(0));
    checkOutput("sat_pre_done", 192'(bus_s.done), 192'(0));
    tick();
    checkOutput("sat_done", 192'(bus_s.done), 192'(1));
    checkOutput("sat_flag", 192'(bus_s.sum_sat), 192'(1));
    checkOutput("sat_sum", 192'(bus_s.sum_err), ones129);
    checkOutput("sat_max", 192'(bus_s.max_err), ones128);
    checkOutput("sat_err", 192'(bus_s.err_count), 192'(3));
    tick();
    checkOutput("sat_hold", 192'(bus_s.sum_sat), 192'(1));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
